// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with 2-bit counters on the fetch side, branch/jump resolution, flush and training on the EX side
module branch_predict_unit #(
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 32,
    parameter int PRED_EN = 1
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic [3:0]       branch,
    input  logic [1:0]       jump,
    input  logic             zero,
    input  logic             sgn,
    input  logic             ult,
    input  logic [31:0]      pcimm,
    input  logic [31:0]      aluc,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [DEPTH];
    logic             valid_d  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [TAG_W-1:0] tag_d    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [31:0]      target_d [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];
    logic [1:0]       ctr_d    [DEPTH];
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             hit, ex_hit, ctrl, br_cond, act_taken, mis;
    logic [31:0]      act_target;
    logic [1:0]       ctr_cur;
    logic             unused_bits;

    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_tag      = if_pc[31:IDX_W+2];
    assign ex_idx      = ex_pc[IDX_W+1:2];
    assign ex_tag      = ex_pc[31:IDX_W+2];
    assign br_cnt      = br_cnt_q;
    assign miss_cnt    = miss_cnt_q;
    assign unused_bits = ^{if_pc[1:0], ex_pc[1:0], aluc[0]};

    // Fetch lookup reads only registered state, so a same-cycle update is seen next cycle
    always_comb begin
        hit         = (PRED_EN != 0) && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
    end

    // Resolve the real outcome in EX and compare it with the prediction carried down the pipe
    always_comb begin
        ctrl        = ex_valid && (branch[0] || jump[0]);
        br_cond     = (branch[3:1] == 3'b000) ? zero :
                      (branch[3:1] == 3'b001) ? !zero :
                      (branch[3:1] == 3'b100) ? sgn :
                      (branch[3:1] == 3'b101) ? !sgn :
                      (branch[3:1] == 3'b110) ? ult :
                      (branch[3:1] == 3'b111) ? !ult : 1'b0;
        act_taken   = jump[0] || (branch[0] && br_cond);
        act_target  = (jump == 2'b01) ? {aluc[31:1], 1'b0} : pcimm;
        mis         = ctrl && ((act_taken != ex_pred_taken) ||
                               (act_taken && (act_target != ex_pred_target)));
        flush       = mis;
        redirect_pc = act_taken ? act_target : ex_pc + 32'd4;
    end

    // Next-state of the BTB entry addressed by ex_pc and of the saturating statistics
    always_comb begin
        valid_d    = valid_q;
        tag_d      = tag_q;
        target_d   = target_q;
        ctr_d      = ctr_q;
        ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ctr_cur    = ctr_q[ex_idx];
        if (ctrl) begin
            valid_d[ex_idx]  = 1'b1;
            tag_d[ex_idx]    = ex_tag;
            target_d[ex_idx] = act_target;
            ctr_d[ex_idx]    = jump[0] ? 2'd3 :
                               !ex_hit ? (act_taken ? 2'd2 : 2'd1) :
                               act_taken ? ((ctr_cur == 2'd3) ? 2'd3 : ctr_cur + 2'd1) :
                               ((ctr_cur == 2'd0) ? 2'd0 : ctr_cur - 2'd1);
        end
        br_cnt_d   = br_cnt_q + CNT_W'(ctrl && !(&br_cnt_q));
        miss_cnt_d = miss_cnt_q + CNT_W'(mis && !(&miss_cnt_q));
    end

    // Table and counter registers; reset has priority over any training in the same cycle
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
            end
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed scenarios plus randomized traffic checked against a table-level model
module tb_branch_predict_unit;
    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic [3:0]  branch = '0;
    logic [1:0]  jump = '0;
    logic        zero = 1'b0, sgn = 1'b0, ult = 1'b0;
    logic [31:0] pcimm = '0, aluc = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt, miss_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] cur_a = '0, cur_b = '0;
    bit          m_valid [16];
    int unsigned m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_ctr [16];
    int unsigned m_br, m_miss;

    branch_predict_unit dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .branch(branch), .jump(jump),
        .zero(zero), .sgn(sgn), .ult(ult), .pcimm(pcimm), .aluc(aluc),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .flush(flush), .redirect_pc(redirect_pc), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_ctr[i] = 1;
        end
        m_br = 0;
        m_miss = 0;
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int i;
        i = int'((pc >> 2) % 16);
        tk = m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
        tg = tk ? m_tgt[i] : pc + 4;
    endfunction

    function automatic void m_resolve(output logic ctl, output logic tk, output logic [31:0] tg, output logic mis);
        logic cond;
        ctl = ex_valid && (branch[0] || jump[0]);
        case (branch[3:1])
            3'd0: cond = (cur_a == cur_b);
            3'd1: cond = (cur_a != cur_b);
            3'd4: cond = ($signed(cur_a) < $signed(cur_b));
            3'd5: cond = ($signed(cur_a) >= $signed(cur_b));
            3'd6: cond = (cur_a < cur_b);
            3'd7: cond = (cur_a >= cur_b);
            default: cond = 0;
        endcase
        tk = (jump == 2'b01) || (jump == 2'b11) || (branch[0] && cond);
        tg = (jump == 2'b01) ? (aluc & 32'hFFFF_FFFE) : pcimm;
        mis = ctl && ((tk != ex_pred_taken) || (tk && tg != ex_pred_target));
    endfunction

    function automatic void m_train();
        logic ctl, tk, mis;
        logic [31:0] tg;
        int i;
        m_resolve(ctl, tk, tg, mis);
        if (!ctl) return;
        i = int'((ex_pc >> 2) % 16);
        if (jump[0]) m_ctr[i] = 3;
        else if (m_valid[i] && m_tag[i] == (ex_pc >> 6)) m_ctr[i] = tk ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        else m_ctr[i] = tk ? 2 : 1;
        m_valid[i] = 1;
        m_tag[i] = ex_pc >> 6;
        m_tgt[i] = tg;
        m_br++;
        if (mis) m_miss++;
    endfunction

    task automatic tick();
        if (cpu_rst) m_reset();
        else m_train();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [3:0] br, input logic [1:0] jp,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] pi, input logic [31:0] al,
                          input logic pt, input logic [31:0] ptg);
        ex_valid = v; ex_pc = pc; branch = br; jump = jp;
        cur_a = a; cur_b = b;
        zero = (a == b); sgn = ($signed(a) < $signed(b)); ult = (a < b);
        pcimm = pi; aluc = al; ex_pred_taken = pt; ex_pred_target = ptg;
        #1;
    endtask

    task automatic test_reset();
        cpu_rst = 1;
        tick();
        tick();
        cpu_rst = 0;
        if_pc = 32'h0000_1234;
        set_ex(0, 32'h100, 4'b0001, 2'b00, 7, 7, 32'h140, 0, 0, 0);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h0000_1238) begin errors++; $display("FAIL reset_pred_target got %h exp 00001238", pred_target); end
        checks++; if (br_cnt !== 0 || miss_cnt !== 0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", br_cnt, miss_cnt); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush_invalid got %0b exp 0", flush); end
    endtask

    task automatic test_cold_beq();
        set_ex(1, 32'h100, 4'b0001, 2'b00, 5, 5, 32'h140, 0, 0, 0);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL cold_beq_flush got %0b exp 1", flush); end
        checks++; if (redirect_pc !== 32'h140) begin errors++; $display("FAIL cold_beq_redirect got %h exp 00000140", redirect_pc); end
        tick();
        ex_valid = 0;
        if_pc = 32'h100;
        #1;
        checks++; if (miss_cnt !== 1 || br_cnt !== 1) begin errors++; $display("FAIL cold_beq_counts got %0d/%0d exp 1/1", br_cnt, miss_cnt); end
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h140) begin errors++; $display("FAIL cold_beq_predict got %0b %h exp 1 00000140", pred_taken, pred_target); end
    endtask

    task automatic test_training();
        bit   outcome [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
        bit   exp_pt  [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        logic tk;
        logic [31:0] tg;
        for (int s = 0; s < 9; s++) begin
            if_pc = 32'h200;
            #1;
            m_lookup(32'h200, tk, tg);
            set_ex(1, 32'h200, 4'b0011, 2'b00, 1, outcome[s] ? 2 : 1, 32'h280, 0, tk, tg);
            tick();
            ex_valid = 0;
            #1;
            checks++;
            if (pred_taken !== exp_pt[s]) begin errors++; $display("FAIL training_step%0d got %0b exp %0b", s, pred_taken, exp_pt[s]); end
        end
    endtask

    task automatic test_jalr();
        set_ex(1, 32'h300, 4'b0000, 2'b01, 0, 0, 32'h999, 32'h2001, 1, 32'h3000);
        checks++; if (flush !== 1'b1 || redirect_pc !== 32'h2000) begin errors++; $display("FAIL jalr_wrong_target got %0b %h exp 1 00002000", flush, redirect_pc); end
        tick();
        ex_valid = 0;
        if_pc = 32'h300;
        #1;
        checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h2000) begin errors++; $display("FAIL jalr_entry got %0b %h exp 1 00002000", pred_taken, pred_target); end
        set_ex(1, 32'h300, 4'b0000, 2'b01, 0, 0, 32'h999, 32'h2001, 1, 32'h2000);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL jalr_correct got %0b exp 0", flush); end
        tick();
    endtask

    task automatic test_unsigned();
        set_ex(1, 32'h400, 4'b1101, 2'b00, 1, 32'hFFFF_FFFF, 32'h480, 0, 0, 0);
        checks++; if (flush !== 1'b1 || redirect_pc !== 32'h480) begin errors++; $display("FAIL bltu_taken got %0b %h exp 1 00000480", flush, redirect_pc); end
        set_ex(1, 32'h400, 4'b1111, 2'b00, 1, 32'hFFFF_FFFF, 32'h480, 0, 0, 0);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL bgeu_not_taken got %0b exp 0", flush); end
        set_ex(1, 32'h400, 4'b0101, 2'b00, 3, 3, 32'h480, 0, 1, 32'h480);
        checks++; if (flush !== 1'b1 || redirect_pc !== 32'h404) begin errors++; $display("FAIL reserved_pred_taken got %0b %h exp 1 00000404", flush, redirect_pc); end
        set_ex(1, 32'h400, 4'b0101, 2'b00, 3, 3, 32'h480, 0, 0, 0);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reserved_pred_nt got %0b exp 0", flush); end
        ex_valid = 0;
    endtask

    task automatic test_alias();
        set_ex(1, 32'h4, 4'b0001, 2'b00, 2, 2, 32'h80, 0, 1, 32'h80);
        tick();
        set_ex(1, 32'h44, 4'b0000, 2'b11, 0, 0, 32'h90, 0, 1, 32'h90);
        tick();
        ex_valid = 0;
        if_pc = 32'h4;
        #1;
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h8) begin errors++; $display("FAIL alias_miss got %0b %h exp 0 00000008", pred_taken, pred_target); end
        if_pc = 32'h44;
        set_ex(1, 32'h44, 4'b0000, 2'b11, 0, 0, 32'hA0, 0, 1, 32'h90);
        checks++; if (pred_target !== 32'h90 || flush !== 1'b1) begin errors++; $display("FAIL same_cycle_old got %h %0b exp 00000090 1", pred_target, flush); end
        tick();
        ex_valid = 0;
        #1;
        checks++; if (pred_target !== 32'hA0) begin errors++; $display("FAIL same_cycle_new got %h exp 000000a0", pred_target); end
        cpu_rst = 1;
        tick();
        cpu_rst = 0;
        tick();
        set_ex(1, 32'h8, 4'b0001, 2'b00, 4, 4, 32'hC0, 0, 0, 0);
        cpu_rst = 1;
        tick();
        cpu_rst = 0;
        ex_valid = 0;
        if_pc = 32'h8;
        #1;
        checks++; if (br_cnt !== 0 || miss_cnt !== 0) begin errors++; $display("FAIL rst_mispredict_counts got %0d/%0d exp 0/0", br_cnt, miss_cnt); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_mispredict_valid got %0b exp 0", pred_taken); end
    endtask

    task automatic test_random();
        logic ctl, tk, mis, ptk, ltk;
        logic [31:0] tg, ptg, ltg, pc, a, b;
        logic [3:0] br;
        logic [1:0] jp;
        int op;
        for (int n = 0; n < 400; n++) begin
            pc = 32'h1000 + 4 * $urandom_range(0, 15) + 64 * $urandom_range(0, 2);
            op = $urandom_range(0, 9);
            br = (op < 6) ? {(op < 2) ? {2'b00, op[0]} : {1'b1, op[1:0] - 2'd2}, 1'b1} :
                 (op == 6) ? {3'b011, 1'b1} : 4'b0000;
            jp = (op == 7) ? 2'b01 : (op == 8) ? 2'b11 : 2'b00;
            a = $urandom_range(0, 3);
            b = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) a = a ^ 32'h8000_0000;
            m_lookup(pc, ptk, ptg);
            if ($urandom_range(0, 3) == 0) begin
                ptk = $urandom_range(0, 1);
                ptg = 32'h2000 + 4 * $urandom_range(0, 3);
            end
            if_pc = 32'h1000 + 4 * $urandom_range(0, 15) + 64 * $urandom_range(0, 2);
            set_ex($urandom_range(0, 7) != 0, pc, br, jp, a, b,
                   32'h2000 + 4 * $urandom_range(0, 3), 32'h2000 + $urandom_range(0, 15), ptk, ptg);
            m_resolve(ctl, tk, tg, mis);
            m_lookup(if_pc, ltk, ltg);
            checks++; if (flush !== mis) begin errors++; $display("FAIL rand%0d_flush got %0b exp %0b", n, flush, mis); end
            if (mis) begin
                checks++;
                if (redirect_pc !== (tk ? tg : pc + 4)) begin errors++; $display("FAIL rand%0d_redirect got %h exp %h", n, redirect_pc, tk ? tg : pc + 4); end
            end
            checks++; if (pred_taken !== ltk || pred_target !== ltg) begin errors++; $display("FAIL rand%0d_lookup got %0b %h exp %0b %h", n, pred_taken, pred_target, ltk, ltg); end
            checks++; if (br_cnt !== m_br || miss_cnt !== m_miss) begin errors++; $display("FAIL rand%0d_counts got %0d/%0d exp %0d/%0d", n, br_cnt, miss_cnt, m_br, m_miss); end
            tick();
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_cold_beq();
        test_training();
        test_jalr();
        test_unsigned();
        test_alias();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the EX-stage branch/jump resolver in the pipelined miniRV core.
- IF side: a direct-mapped BTB with 2-bit saturating counters, looked up combinationally on the fetch PC.
- EX side: resolves the real outcome (beq/bne/blt/bge plus new bltu/bgeu), detects mispredictions, drives flush/redirect, trains the tables and keeps saturating statistics counters.

Parameters:
- IDX_W, 4, BTB index width; depth = 2**IDX_W entries, index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
- CNT_W, 32, width of the statistics counters.
- PRED_EN, 1, 0 = static not-taken; lookup forced off, tables still trained.

Ports:
- cpu_clk  in  1  core clock.
- cpu_rst  in  1  synchronous active-high reset.
- if_pc  in  32  fetch PC.
- pred_taken  out  1  IF prediction.
- pred_target  out  32  predicted next PC (if_pc+4 when not taken).
- ex_valid  in  1  EX holds a valid instruction.
- ex_pc  in  32  EX PC.
- branch  in  4  [0]=is_branch; [3:1]: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; 010/011 reserved (not taken).
- jump  in  2  01 jalr, 11 jal, else none.
- zero  in  1  ALU equal.
- sgn  in  1  signed less-than.
- ult  in  1  unsigned less-than.
- pcimm  in  32  pc+imm.
- aluc  in  32  ALU result (jalr target source).
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  32  prediction carried down the pipe.
- flush  out  1  mispredict; kill IF/ID.
- redirect_pc  out  32  correct next PC.
- br_cnt  out  CNT_W  resolved control instructions.
- miss_cnt  out  CNT_W  mispredictions.

Behaviour:
- Storage per entry: valid, tag, target[31:0], ctr[1:0].
- Reset (synchronous, cpu_rst=1 at edge): all valid=0, all ctr=2'b01, br_cnt=miss_cnt=0.
- After reset: pred_taken=0, pred_target=if_pc+4, flush=0.
- Lookup (combinational, same cycle):
  - hit = PRED_EN && valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target[idx] : if_pc+4.
- Actual outcome (combinational):
  - ctrl = ex_valid && (branch[0] || jump[0]).
  - Taken: jump[0] -> taken; branch per encoding (beq zero, bne !zero, blt sgn, bge !sgn, bltu ult, bgeu !ult); otherwise not taken.
  - Target: jalr = {aluc[31:1],1'b0}; otherwise pcimm.
- Mispredict (combinational):
  - mis = ctrl && (act_taken != ex_pred_taken || (act_taken && act_target != ex_pred_target)).
  - flush = mis.
  - redirect_pc = act_taken ? act_target : ex_pc+4.
  - redirect_pc is don't-care when flush=0.
  - Non-control or invalid EX: flush=0, mis=0.
  - A non-control instruction that was predicted taken (alias) is not flagged here; that is an ID-stage concern.
- Training (on cpu_clk edge when ctrl && !cpu_rst), at idx/tag of ex_pc:
  - Always write valid=1, tag, target=act_target.
  - Jump: ctr=3.
  - Branch, tag hit: ctr saturating +1 if taken, -1 if not (bounds 0..3).
  - Branch, tag miss (allocation): ctr = taken ? 2 : 1.
  - Not-taken branches are allocated too.
- Same-cycle lookup and training of the same entry: lookup returns the old contents (no bypass). The new value is visible from the next cycle.
- Statistics (on edge):
  - br_cnt += ctrl.
  - miss_cnt += mis.
  - Both saturate at all-ones; no wrap.
- cpu_rst asserted while a mispredict is in EX: no table or counter update that cycle; reset wins.
- PRED_EN=0: pred_taken=0 always; any taken control in EX flushes.

Test Plan:
- Reset -> pred_taken=0, pred_target=if_pc+4; br_cnt=miss_cnt=0; flush=0 with ex_valid=0.
- Cold beq, ex_pc=0x100, zero=1, pcimm=0x140, ex_pred_taken=0:
  - flush=1, redirect_pc=0x140, miss_cnt=1.
  - Next cycle: if_pc=0x100 -> pred_taken=1 (ctr=2), pred_target=0x140.
- Training loop:
  - Same bne resolved taken 3x -> ctr=3.
  - Then not-taken once -> ctr=2, still predicts taken.
  - Second not-taken -> ctr=1, prediction not-taken.
  - Counters never exceed 3 nor go below 0.
- jalr, aluc=0x2001, ex_pred_taken=1, ex_pred_target=0x3000:
  - flush=1, redirect_pc=0x2000; entry target updated to 0x2000.
  - Repeat with ex_pred_target=0x2000 -> flush=0.
- bltu/bgeu with sgn=0, ult=1:
  - bltu taken, bgeu not taken.
  - Reserved branch[3:1]=010 -> not taken; flush iff ex_pred_taken=1, redirect_pc=ex_pc+4.
- Aliasing / simultaneous events, IDX_W=4, pcs 0x0004 and 0x0044:
  - Second overwrites the tag; lookup of 0x0004 misses.
  - Lookup and train of the same index in one cycle -> old value returned.
  - cpu_rst during a mispredicting branch -> counters stay 0, valid stays 0.
